// File: rtl/fp_addsub_exec_pipe.sv
//------------------------------------------------------------------------------
// Module   : fp_addsub_exec_pipe
// Brief    : Mantissa add/subtract execution pipe with valid/ready flow control
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_addsub_exec_pipe #(
  parameter int MAN_W  = 23,
  parameter int GRD_W  = 8,
  parameter int STAGES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W-1:0]       mmax,
  input  logic [MAN_W+GRD_W:0]   mmin,
  input  logic                   sa,
  input  logic                   sb,
  input  logic                   max_ab,
  input  logic                   op_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MAN_W+GRD_W+1:0] sum,
  output logic                   psgn,
  output logic                   opr,
  output logic                   zero,
  output logic                   borrow
);

  localparam int c_SW = MAN_W + GRD_W + 2;
  localparam int c_MW = MAN_W + GRD_W + 1;
  localparam int c_PW = MAN_W + c_MW + 4;

  generate
    if (STAGES < 1 || STAGES > 6) begin : g_bad_stages
      $error("fp_addsub_exec_pipe: STAGES must be in 1..6");
    end
  endgenerate

  logic            w_adv;
  logic            w_acc;
  logic [c_PW-1:0] w_pay_in;
  logic [c_PW-1:0] w_fin_pay;
  logic            w_fin_vld;

  logic            r_out_valid;
  logic [c_SW-1:0] r_sum;
  logic            r_psgn;
  logic            r_opr;
  logic            r_zero;
  logic            r_borrow;

  // Whole pipe advances as one; a stalled output freezes every stage behind it.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = !rst && w_adv;
  assign w_acc    = in_valid && in_ready;
  assign w_pay_in = {mmax, mmin, sa, sb, max_ab, op_mode};

  generate
    if (STAGES > 1) begin : g_delay
      logic [c_PW-1:0]   r_pay [STAGES-1];
      logic [STAGES-2:0] r_vld;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld <= '0;
        end else if (w_adv) begin
          r_vld[0] <= w_acc;
          for (int i = 1; i < STAGES - 1; i++) begin
            r_vld[i] <= r_vld[i-1];
          end
        end
      end

      // Payload needs no reset: it is only ever qualified by its valid bit.
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_pay[0] <= w_pay_in;
          for (int i = 1; i < STAGES - 1; i++) begin
            r_pay[i] <= r_pay[i-1];
          end
        end
      end

      assign w_fin_pay = r_pay[STAGES-2];
      assign w_fin_vld = r_vld[STAGES-2];
    end else begin : g_bypass
      assign w_fin_pay = w_pay_in;
      assign w_fin_vld = w_acc;
    end
  endgenerate

  logic [MAN_W-1:0] w_mmax;
  logic [c_MW-1:0]  w_mmin;
  logic             w_sa;
  logic             w_sb;
  logic             w_max_ab;
  logic             w_op_mode;

  assign {w_mmax, w_mmin, w_sa, w_sb, w_max_ab, w_op_mode} = w_fin_pay;

  logic [c_SW-1:0] w_x;
  logic [c_SW-1:0] w_y;
  logic            w_opr;
  logic [c_SW-1:0] w_res;
  logic            w_zero;
  logic            w_borrow;
  logic            w_psgn;

  assign w_x      = {1'b0, 1'b1, w_mmax, {GRD_W{1'b0}}};
  assign w_y      = {1'b0, w_mmin};
  assign w_opr    = w_op_mode ^ w_sa ^ w_sb;
  assign w_res    = w_opr ? (w_x - w_y) : (w_x + w_y);
  assign w_zero   = (w_res == '0);
  // A negative difference is a caller contract violation; flagged, not corrected.
  assign w_borrow = w_opr && (w_y > w_x);
  // Exact cancellation always yields +0 regardless of operand signs.
  assign w_psgn   = (w_opr && w_zero) ? 1'b0 : (w_max_ab ? w_sb : w_sa);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_psgn      <= 1'b0;
      r_opr       <= 1'b0;
      r_zero      <= 1'b0;
      r_borrow    <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_fin_vld;
      if (w_fin_vld) begin
        r_sum    <= w_res;
        r_psgn   <= w_psgn;
        r_opr    <= w_opr;
        r_zero   <= w_zero;
        r_borrow <= w_borrow;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign psgn      = r_psgn;
  assign opr       = r_opr;
  assign zero      = r_zero;
  assign borrow    = r_borrow;

endmodule

`default_nettype wire

// File: doc/fp_addsub_exec_pipe.md
FP_ADDSUB_EXEC_PIPE -- requirements
Module: fp_addsub_exec_pipe

Interface
REQ-001 SHALL have parameter MAN_W, default 23, meaning stored mantissa width of the larger operand (hidden bit excluded).
REQ-002 SHALL have parameter GRD_W, default 8, meaning guard/round/sticky bits carried below the mantissa LSB.
REQ-003 SHALL have parameter STAGES, default 3, legal 1..6, meaning pipeline register stages from input to output.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports named clk and rst.
REQ-005 SHALL have ports, in order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block accepts operands this cycle.
- mmax  in  MAN_W  larger mantissa, hidden 1 implied.
- mmin  in  MAN_W+1+GRD_W  smaller mantissa, pre-aligned, hidden bit and guard bits included.
- sa  in  1  sign of larger operand.
- sb  in  1  sign of smaller operand.
- max_ab  in  1  larger operand is B (1) or A (0).
- op_mode  in  1  requested operation (0 add, 1 sub).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  SW=MAN_W+GRD_W+2  result magnitude, MSB is carry-out.
- psgn  out  1  result sign.
- opr  out  1  effective operation (0 add, 1 sub).
- zero  out  1  sum is all zeros.
- borrow  out  1  subtraction went negative (operand-order contract violated).

Function
REQ-006 SHALL compute opr = op_mode ^ sa ^ sb.
REQ-007 SHALL form X = {1'b0, 1'b1, mmax, GRD_W zeros} and Y = {1'b0, mmin}, both SW bits.
REQ-008 SHALL output sum = X + Y when opr=0, and sum = X - Y modulo 2^SW when opr=1.
REQ-009 SHALL assert borrow only when opr=1 and Y > X; sum then holds the two's-complement wrap value, unmodified.
REQ-010 SHALL output psgn = (max_ab ? sb : sa), except psgn = 0 when opr=1 and the result is zero (exact cancellation gives +0).
REQ-011 SHALL assert zero iff sum == 0.
REQ-012 SHALL register the arithmetic result in the final stage; the intermediate stages only delay it.
- Latency from accepting handshake to out_valid is exactly STAGES cycles with out_ready held high.
REQ-013 SHALL accept an input on a cycle where in_valid and in_ready are both high.
REQ-014 SHALL deliver an output on a cycle where out_valid and out_ready are both high.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (global advance enable).
- All stages advance together when enabled.
- Empty slots advance as bubbles.
REQ-016 SHALL keep a per-stage valid bit; bubbles are never presented as out_valid.
REQ-017 SHALL hold sum, psgn, opr, zero, borrow and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL sustain one result per cycle with in_valid and out_ready continuously high.
REQ-019 SHALL deliver results in acceptance order, with no loss and no duplication, under any out_ready pattern.
REQ-020 SHALL ignore input data on cycles without a handshake.
REQ-021 SHALL, on a cycle where the output is consumed and a new input is accepted, perform both in that cycle.

Reset
REQ-022 SHALL, when rst=1 at a clock edge, clear all stage valid bits and drive on the next cycle:
- out_valid = 0, sum = 0, psgn = 0, opr = 0, zero = 0, borrow = 0.
REQ-023 SHALL discard all in-flight operands on reset mid-operation, and SHALL NOT accept input while rst=1 (in_ready = 0).
REQ-024 SHALL raise in_ready on the first cycle after rst deasserts.

Verification (defaults MAN_W=23, GRD_W=8, STAGES=3, SW=33)
REQ-025 SHALL cover addition: mmax=0, mmin=0x8000_0000, sa=sb=0, op_mode=0 -> after 3 cycles sum=0x1_0000_0000, opr=0, psgn=0, zero=0.
REQ-026 SHALL cover exact cancellation: mmax=0, mmin=0x8000_0000, sa=1, sb=1, op_mode=1, max_ab=0 -> sum=0, zero=1, opr=1, psgn=0.
REQ-027 SHALL cover effective subtraction through sign mismatch: sa=0, sb=1, op_mode=0, mmax=0x40_0000, mmin=0x0000_0100 -> opr=1, sum=0xBFFF_FF00, psgn=0.
REQ-028 SHALL cover backpressure: 8 back-to-back inputs, out_ready low on cycles 4-8 -> all 8 results in order, outputs stable while stalled, in_ready low while stalled with out_valid=1.
REQ-029 SHALL cover reset mid-operation: rst pulsed with 3 results in flight -> out_valid=0 next cycle, none of the 3 ever emitted, a new operand after reset emerges 3 cycles after acceptance.
REQ-030 SHALL cover contract violation: mmax=0, mmin=0x1_0000_0000 >> 1 plus 1 (0x8000_0001), opr=1 -> borrow=1, sum=0x1_FFFF_FFFF.
